mux4_scan_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the 4:1 mux. It drives the mux select `sel[1:0]` round-robin across channels 0..3.
- It samples the mux's 1-bit output and assembles the four channel values into a 4-bit snapshot for downstream logic.
- It supports single-sweep and continuous scanning, with a programmable dwell time per channel so the combinational mux output settles before capture.

---
 rtl/mux4_scan_ctrl.sv | 86 ++++++++
 tb/tb_mux4_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_scan_ctrl.sv
// Round-robin sequencer for a downstream 4:1 mux: steps sel across channels 0..3,
// dwells DWELL cycles on each, and publishes the four captured bits as one snapshot.
module mux4_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] sample,
    output logic       valid,
    output logic       busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    shadow;
    logic          mode_q;

    // Channel 3 is never stored in the shadow: it is merged straight into sample at the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= 2'd0;
            cnt    <= '0;
            shadow <= 3'b000;
            sample <= 4'b0000;
            valid  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    sel <= 2'd0;
                    cnt <= '0;
                    if (start && !stop) begin
                        state  <= SCAN;
                        mode_q <= mode;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        state  <= IDLE;
                        sel    <= 2'd0;
                        cnt    <= '0;
                        shadow <= 3'b000;
                    end else if (cnt != LAST_CNT) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        cnt <= '0;
                        if (sel != 2'd3) begin
                            shadow[sel] <= mux_out;
                            sel         <= sel + 2'd1;
                        end else begin
                            sample <= {mux_out, shadow};
                            valid  <= 1'b1;
                            sel    <= 2'd0;
                            shadow <= 3'b000;
                            if (mode_q) begin
                                mode_q <= mode;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SCAN);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench for mux4_scan_ctrl: a cycle-count reference model predicts sel/busy
// and the snapshot of each sweep; a negedge monitor compares against the DUT.
module tb_mux4_scan_ctrl;

    localparam int DWELL = 2;
    localparam int CW    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] in_vals = 4'b0000;
    logic       mux_out;
    logic [1:0] sel;
    logic [3:0] sample;
    logic       valid;
    logic       busy;

    int total_checks = 0;
    int fail_checks  = 0;

    // Reference model state: sweep progress is just "cycles since sweep start".
    logic       m_busy   = 1'b0;
    int         m_phase  = 0;
    logic       m_mode   = 1'b0;
    logic [3:0] m_shadow = 4'b0000;
    logic [3:0] m_sample = 4'b0000;
    logic       m_valid  = 1'b0;
    logic [3:0] exp_q[$];

    mux4_scan_ctrl #(.DWELL(DWELL), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .mux_out (mux_out),
        .sel     (sel),
        .sample  (sample),
        .valid   (valid),
        .busy    (busy)
    );

    assign mux_out = in_vals[sel];

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [3:0] actual, input logic [3:0] expected);
        total_checks++;
        if (actual !== expected) begin
            fail_checks++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Channel k is captured DWELL*(k+1) cycles into the sweep; the snapshot lands at 4*DWELL.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_phase = 0;
                m_mode = 1'b0;
                m_shadow = 4'b0000;
                m_sample = 4'b0000;
                m_valid = 1'b0;
                exp_q.delete();
            end else begin
                m_valid = 1'b0;
                if (m_busy) begin
                    if (stop) begin
                        m_busy = 1'b0;
                        m_phase = 0;
                        m_shadow = 4'b0000;
                    end else begin
                        m_phase++;
                        if (m_phase % DWELL == 0) begin
                            int k;
                            k = m_phase / DWELL - 1;
                            m_shadow[k] = in_vals[k];
                        end
                        if (m_phase == 4 * DWELL) begin
                            exp_q.push_back(m_shadow);
                            m_sample = m_shadow;
                            m_valid = 1'b1;
                            m_phase = 0;
                            m_shadow = 4'b0000;
                            if (m_mode) m_mode = mode;
                            else m_busy = 1'b0;
                        end
                    end
                end else if (start && !stop) begin
                    m_busy = 1'b1;
                    m_phase = 0;
                    m_mode = mode;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp_sel;
        exp_sel = m_busy ? 2'(m_phase / DWELL) : 2'd0;
        check_output("sel", {2'b00, sel}, {2'b00, exp_sel});
        check_output("busy", {3'b000, busy}, {3'b000, m_busy});
        check_output("valid", {3'b000, valid}, {3'b000, m_valid});
        check_output("sample_hold", sample, m_sample);
        if (valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid", 4'd1, 4'd0);
            end else begin
                logic [3:0] exp_s;
                exp_s = exp_q.pop_front();
                check_output("snapshot", sample, exp_s);
            end
        end
    end

    task automatic apply_stimulus(input logic s, input logic p, input logic m, input logic [3:0] iv);
        @(negedge clk);
        start = s;
        stop = p;
        mode = m;
        in_vals = iv;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, mode, in_vals);
    endtask

    task automatic wait_phase(input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_busy && m_phase == target) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check_output("wait_phase_timeout", 4'd1, 4'd0);
    endtask

    task automatic wait_valid();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (valid) found = 1'b1;
        end
        if (!found) check_output("wait_valid_timeout", 4'd1, 4'd0);
    endtask

    initial begin
        $display("[TB] start, DWELL=%0d", DWELL);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Single sweep over inputs 1,0,1,1.
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b1101);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1101);
        idle_cycles(4 * DWELL + 3);

        // Continuous sweeps; inputs change after the first snapshot.
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'b0110);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'b0110);
        wait_valid();
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1001);
        idle_cycles(8 * DWELL + 4);

        // Stop while sel=2 after a sweep left sample=1010.
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b1010);
        wait_valid();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0101);
        wait_phase(2 * DWELL);
        start = 1'b0;
        stop = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0101);
        idle_cycles(3);

        // Stop on the final-capture edge, then start and stop together in IDLE.
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b1111);
        wait_phase(4 * DWELL - 1);
        start = 1'b0;
        stop = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'b1111);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'b1111);
        idle_cycles(3);

        // Extra start pulse mid-sweep at sel=1, cnt=1 is ignored.
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0011);
        wait_phase(DWELL + 1);
        start = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0011);
        idle_cycles(4 * DWELL + 2);

        // Asynchronous reset mid-sweep after a snapshot of 0111.
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0111);
        wait_valid();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b1110);
        wait_phase(5);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_sel", {2'b00, sel}, 4'd0);
        check_output("rst_sample", sample, 4'd0);
        check_output("rst_valid", {3'b000, valid}, 4'd0);
        check_output("rst_busy", {3'b000, busy}, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b1011);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1011);
        idle_cycles(4 * DWELL + 3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom_range(3) == 0), ($urandom_range(39) == 0),
                           1'($urandom_range(1)), 4'($urandom));
        end
        stop = 1'b0;
        idle_cycles(4 * DWELL * 3);
        mode = 1'b0;
        idle_cycles(4 * DWELL * 3);
        check_output("queue_drained", 4'(exp_q.size()), 4'd0);

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule
